// File: rtl/batchnorm_sequencer_pkg.sv
// Shared batchnorm constants, sequencer state type and counter sizing helper.
// No logic here; latency and backpressure are defined by the modules that import it.
package batchnorm_sequencer_pkg;

    localparam int BN_WIDTH      = 16;
    localparam int BN_FRAC       = 8;
    localparam int BN_BATCH_SIZE = 10;
    localparam int BN_FIN_LAT    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_FINAL,
        ST_REPLAY,
        ST_DONE
    } bn_state_t;

    // Bits needed to hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/batchnorm_sequencer_buf.sv
// Batch sample store: synchronous write, asynchronous read, no reset.
// Read data valid in the same cycle as the address; no backpressure (caller gates writes).
module bn_sample_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 10,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The replay pointer parks one past the end after a batch; return zero there.
    assign o_rd_data = (int'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/batchnorm_sequencer.sv
// Sequences one batch: clear accumulator, load BATCH_SIZE samples, finalize FIN_LAT cycles, replay, done.
// Latency: 2 + BATCH_SIZE + FIN_LAT + BATCH_SIZE + 1 cycles unstalled; s_valid low stalls LOAD, m_ready low stalls REPLAY.
module batchnorm_sequencer
    import batchnorm_sequencer_pkg::*;
#(
    parameter int WIDTH      = BN_WIDTH,
    parameter int FRAC       = BN_FRAC,
    parameter int BATCH_SIZE = BN_BATCH_SIZE,
    parameter int FIN_LAT    = BN_FIN_LAT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    output logic             o_acc_clr,
    output logic             o_acc_en,
    output logic [WIDTH-1:0] o_acc_data,
    output logic             o_acc_final,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [WIDTH-1:0] o_m_data,
    output logic             o_m_last
);

    localparam int CW = cnt_width(BATCH_SIZE);
    localparam int FW = cnt_width(FIN_LAT);
    localparam logic [CW-1:0] LAST_IDX = CW'(BATCH_SIZE - 1);
    localparam logic [FW-1:0] FIN_LAST = FW'(FIN_LAT - 1);
    localparam bit CFG_OK = (FRAC >= 0) && (FRAC <= WIDTH) &&
                            (BATCH_SIZE >= 2) && (BATCH_SIZE <= 255) &&
                            (FIN_LAT >= 1) && (FIN_LAT <= 15);

    bn_state_t     r_state;
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;
    logic [FW-1:0] r_fin_cnt;

    logic w_run;
    logic w_s_xfer;
    logic w_m_xfer;

    a_cfg_ok: assert property (@(posedge i_clk) CFG_OK);

    // Outputs decode the state register and are forced low while reset is held.
    assign w_run       = !i_rst;
    assign o_busy      = w_run && (r_state != ST_IDLE);
    assign o_done      = w_run && (r_state == ST_DONE);
    assign o_acc_clr   = w_run && (r_state == ST_CLEAR);
    assign o_s_ready   = w_run && (r_state == ST_LOAD);
    assign o_acc_final = w_run && (r_state == ST_FINAL) && (r_fin_cnt == '0);
    assign o_m_valid   = w_run && (r_state == ST_REPLAY);
    assign o_m_last    = o_m_valid && (r_rd_cnt == LAST_IDX);

    assign w_s_xfer    = o_s_ready && i_s_valid;
    assign w_m_xfer    = o_m_valid && i_m_ready;
    assign o_acc_en    = w_s_xfer;
    assign o_acc_data  = i_s_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_fin_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    r_wr_cnt  <= '0;
                    r_rd_cnt  <= '0;
                    r_fin_cnt <= '0;
                    r_state   <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_s_xfer) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                        if (r_wr_cnt == LAST_IDX) begin
                            r_state <= ST_FINAL;
                        end
                    end
                end
                ST_FINAL: begin
                    if (r_fin_cnt == FIN_LAST) begin
                        r_state <= ST_REPLAY;
                    end else begin
                        r_fin_cnt <= r_fin_cnt + 1'b1;
                    end
                end
                ST_REPLAY: begin
                    if (w_m_xfer) begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                        if (r_rd_cnt == LAST_IDX) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    bn_sample_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BATCH_SIZE),
        .AW    (CW)
    ) u_buf (
        .i_clk     (i_clk),
        .i_wr_en   (w_s_xfer),
        .i_wr_addr (r_wr_cnt),
        .i_wr_data (i_s_data),
        .i_rd_addr (r_rd_cnt),
        .o_rd_data (o_m_data)
    );

endmodule

// File: tb/tb_batchnorm_sequencer.sv
// Bench for batchnorm_sequencer: timeline table, directed corner sequences, randomized batches.
module tb_batchnorm_sequencer;

    localparam int WIDTH = 16;
    localparam int B     = 10;
    localparam int FL    = 2;
    localparam int NCYC  = 30;

    logic clk = 1'b0;
    logic rst, start, s_valid, m_ready;
    logic [WIDTH-1:0] s_data;
    logic busy, done, s_ready, acc_clr, acc_en, acc_final, m_valid, m_last;
    logic [WIDTH-1:0] acc_data, m_data;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    batchnorm_sequencer #(
        .WIDTH      (WIDTH),
        .FRAC       (8),
        .BATCH_SIZE (B),
        .FIN_LAT    (FL)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .i_s_valid   (s_valid),
        .o_s_ready   (s_ready),
        .i_s_data    (s_data),
        .o_acc_clr   (acc_clr),
        .o_acc_en    (acc_en),
        .o_acc_data  (acc_data),
        .o_acc_final (acc_final),
        .o_m_valid   (m_valid),
        .i_m_ready   (m_ready),
        .o_m_data    (m_data),
        .o_m_last    (m_last)
    );

    // flags = {busy, done, s_ready, acc_clr, acc_en, acc_final, m_valid, m_last}
    typedef struct {
        logic             rst;
        logic             start;
        logic             s_valid;
        logic             m_ready;
        logic [WIDTH-1:0] s_data;
        logic [7:0]       flags;
        logic [WIDTH-1:0] acc_data;
        logic [WIDTH-1:0] m_data;
    } vec_t;

    vec_t tbl [NCYC];

    function automatic logic [7:0] act_flags();
        return {busy, done, s_ready, acc_clr, acc_en, acc_final, m_valid, m_last};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // One full batch checked against the protocol rules: acc_clr right after start,
    // accepted samples in order, acc_final one cycle after the last accept, FL cycles
    // of finalize, replay of the same queue, then a single done cycle.
    task automatic do_batch(input int vpct, input int rpct, input bit noise, input int hold_idx);
        logic [WIDTH-1:0] q[$];
        int acc, idx, stall, guard;
        start   = 1'b1;
        s_valid = 1'($urandom_range(1));
        m_ready = 1'($urandom_range(1));
        settle();
        chk("idle_busy", busy, 0);
        chk("idle_acc_en", acc_en, 0);
        next();
        start = noise ? 1'($urandom_range(1)) : 1'b0;
        settle();
        chk("clr_acc_clr", acc_clr, 1);
        chk("clr_busy", busy, 1);
        chk("clr_s_ready", s_ready, 0);
        next();
        acc = 0;
        guard = 0;
        s_valid = 1'b0;
        while (acc < B && guard < 2000) begin
            if (vpct < 0) s_valid = ~s_valid;
            else          s_valid = ($urandom_range(99) < vpct);
            s_data = (acc == hold_idx) ? 16'h0300 : WIDTH'($urandom);
            start  = noise && ($urandom_range(3) == 0);
            settle();
            chk("load_s_ready", s_ready, 1);
            chk("load_acc_en", acc_en, s_valid);
            chk("load_acc_final", acc_final, 0);
            if (s_valid) begin
                chk("load_acc_data", acc_data, s_data);
                q.push_back(s_data);
                acc++;
            end
            next();
            guard++;
        end
        if (guard >= 2000) chk("load_timeout", 0, 1);
        for (int f = 0; f < FL; f++) begin
            s_valid = 1'b1;
            start   = noise && ($urandom_range(1) == 0);
            settle();
            chk("fin_acc_final", acc_final, (f == 0));
            chk("fin_s_ready", s_ready, 0);
            chk("fin_acc_en", acc_en, 0);
            chk("fin_m_valid", m_valid, 0);
            chk("fin_busy", busy, 1);
            next();
        end
        idx = 0;
        stall = 0;
        guard = 0;
        while (idx < B && guard < 2000) begin
            if (idx == hold_idx && stall < 3) begin
                m_ready = 1'b0;
                stall++;
            end else begin
                m_ready = ($urandom_range(99) < rpct);
            end
            s_valid = 1'b1;
            start   = noise && ($urandom_range(3) == 0);
            settle();
            chk("rep_m_valid", m_valid, 1);
            chk("rep_m_data", m_data, q[idx]);
            chk("rep_m_last", m_last, (idx == B - 1));
            chk("rep_s_ready", s_ready, 0);
            chk("rep_done", done, 0);
            if (m_ready) idx++;
            next();
            guard++;
        end
        if (guard >= 2000) chk("replay_timeout", 0, 1);
        start   = noise;
        m_ready = 1'($urandom_range(1));
        settle();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_m_valid", m_valid, 0);
        next();
        start   = 1'b0;
        s_valid = 1'b0;
        settle();
        chk("after_done_busy", busy, 0);
        chk("after_done_done", done, 0);
        next();
    endtask

    task automatic reset_mid_batch();
        start = 1'b1;
        settle();
        next();
        start = 1'b0;
        settle();
        chk("rmb_acc_clr", acc_clr, 1);
        next();
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_data  = WIDTH'($urandom);
            settle();
            chk("rmb_acc_en", acc_en, 1);
            next();
        end
        rst = 1'b1;
        settle();
        chk("rmb_in_rst_busy", busy, 0);
        chk("rmb_in_rst_s_ready", s_ready, 0);
        chk("rmb_in_rst_acc_en", acc_en, 0);
        next();
        rst = 1'b0;
        settle();
        chk("rmb_after_busy", busy, 0);
        chk("rmb_after_s_ready", s_ready, 0);
        chk("rmb_after_acc_en", acc_en, 0);
        next();
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        // Reference timeline: reset in cycle 0, start in cycle 3, samples 1..10, m_ready high.
        for (int c = 0; c < NCYC; c++) begin
            tbl[c].rst      = (c == 0);
            tbl[c].start    = (c == 3);
            tbl[c].s_valid  = 1'b1;
            tbl[c].m_ready  = 1'b1;
            tbl[c].s_data   = WIDTH'(c - 4);
            tbl[c].flags    = {(c >= 4 && c <= 27), (c == 27), (c >= 5 && c <= 14), (c == 4),
                               (c >= 5 && c <= 14), (c == 15), (c >= 17 && c <= 26), (c == 26)};
            tbl[c].acc_data = WIDTH'(c - 4);
            tbl[c].m_data   = WIDTH'(c - 16);
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NCYC; c++) begin
            rst     = tbl[c].rst;
            start   = tbl[c].start;
            s_valid = tbl[c].s_valid;
            m_ready = tbl[c].m_ready;
            s_data  = tbl[c].s_data;
            settle();
            chk($sformatf("tl_flags_c%0d", c), act_flags(), tbl[c].flags);
            if (tbl[c].flags[3]) chk($sformatf("tl_acc_data_c%0d", c), acc_data, tbl[c].acc_data);
            if (tbl[c].flags[1]) chk($sformatf("tl_m_data_c%0d", c), m_data, tbl[c].m_data);
            next();
        end
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;
        next();

        do_batch(-1, 100, 1'b0, -1);
        do_batch(100, 100, 1'b0, 3);
        reset_mid_batch();
        do_batch(100, 100, 1'b0, -1);
        for (int k = 0; k < 6; k++) begin
            do_batch(30 + int'($urandom_range(70)), 30 + int'($urandom_range(70)), 1'b1,
                     int'($urandom_range(B)) - 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
